// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: funct3 codes,
// FSM states and store byte-lane masks.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] WME_B = 4'b0001;
  localparam logic [3:0] WME_H = 4'b0011;
  localparam logic [3:0] WME_W = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  // Access size in bytes; 0 flags an illegal funct3.
  function automatic logic [2:0] f3_size(logic [2:0] f3);
    logic [2:0] s;
    s = 3'd0;
    unique case (1'b1)
      (f3 == F3_B),
      (f3 == F3_BU): s = 3'd1;
      (f3 == F3_H),
      (f3 == F3_HU): s = 3'd2;
      (f3 == F3_W):  s = 3'd4;
      default:       s = 3'd0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Builds 32-bit load data from the four memory read lanes,
// sign- or zero-extending according to funct3.
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [7:0]  do0,
  input  logic [7:0]  do1,
  input  logic [7:0]  do2,
  input  logic [7:0]  do3,
  output logic [31:0] rdata
);

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      (funct3 == F3_B):  rdata = {{24{do0[7]}}, do0};
      (funct3 == F3_BU): rdata = {24'd0, do0};
      (funct3 == F3_H):  rdata = {{16{do1[7]}}, do1, do0};
      (funct3 == F3_HU): rdata = {16'd0, do1, do0};
      (funct3 == F3_W):  rdata = {do3, do2, do1, do0};
      default:           rdata = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store initiator: one request at a time, drives the byte-lane
// memory for one ACCESS cycle, then holds the response until taken.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = 1024
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] address,
  output logic [31:0] datain,
  output logic [3:0]  wme,
  input  logic [7:0]  do0,
  input  logic [7:0]  do1,
  input  logic [7:0]  do2,
  input  logic [7:0]  do3
);

  state_t      state_q, state_d;
  logic        rdy_q;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] address_q, address_d;
  logic [31:0] datain_q, datain_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [2:0]  size;
  logic [32:0] end_addr;
  logic        legal;
  logic        accept;
  logic [31:0] ld_data;

  lsu_load_extend u_ext (
    .funct3 (f3_q),
    .do0    (do0),
    .do1    (do1),
    .do2    (do2),
    .do3    (do3),
    .rdata  (ld_data)
  );

  // 33-bit end address so a wrapping access is caught as out of range.
  assign size     = f3_size(req_funct3);
  assign end_addr = {1'b0, req_addr} + {30'd0, size};
  assign legal    = (size != 3'd0)
                  && !(req_we && req_funct3[2])
                  && (end_addr <= 33'(MEM_BYTES));

  assign req_ready = rdy_q && (state_q == S_IDLE);
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign address   = address_q;
  assign datain    = datain_q;

  // Driven from state so a reset during ACCESS kills the write at once.
  always_comb begin
    wme = '0;
    if (state_q == S_ACCESS && we_q) begin
      unique case (1'b1)
        (f3_q == F3_B): wme = WME_B;
        (f3_q == F3_H): wme = WME_H;
        (f3_q == F3_W): wme = WME_W;
        default:        wme = '0;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    f3_d      = f3_q;
    address_d = address_q;
    datain_d  = datain_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          we_d = req_we;
          f3_d = req_funct3;
          if (legal) begin
            address_d = req_addr;
            datain_d  = req_wdata;
            state_d   = S_ACCESS;
          end else begin
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = S_RESP;
          end
        end
      end
      S_ACCESS: begin
        rdata_d = we_q ? 32'd0 : ld_data;
        err_d   = 1'b0;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q   <= S_IDLE;
      rdy_q     <= 1'b0;
      we_q      <= 1'b0;
      f3_q      <= '0;
      address_q <= '0;
      datain_q  <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rdy_q     <= 1'b1;
      we_q      <= we_d;
      f3_q      <= f3_d;
      address_q <= address_d;
      datain_q  <= datain_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-lane memory model.
// Expected values are hand-computed per step.
module tb_load_store_unit;

  localparam int MB = 1024;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata, address, datain;
  logic [3:0]  wme;
  logic [7:0]  do0, do1, do2, do3;

  logic [7:0]  mem [0:MB-1];
  int          wme_cnt = 0;
  int          errors = 0;
  int          checks = 0;

  always #5 CLK = ~CLK;

  load_store_unit #(.MEM_BYTES(MB)) dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .address    (address),
    .datain     (datain),
    .wme        (wme),
    .do0        (do0),
    .do1        (do1),
    .do2        (do2),
    .do3        (do3)
  );

  assign do0 = mem[address[9:0]];
  assign do1 = mem[address[9:0] + 10'd1];
  assign do2 = mem[address[9:0] + 10'd2];
  assign do3 = mem[address[9:0] + 10'd3];

  always @(posedge CLK) begin
    if (wme != 4'd0) wme_cnt++;
    for (int k = 0; k < 4; k++)
      if (wme[k]) mem[address[9:0] + 10'(k)] <= datain[8*k +: 8];
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request and return #1 after the accepting edge.
  task automatic send_req(input logic we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd);
    int n;
    @(negedge CLK);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    n = 0;
    while (!req_ready && n < 8) begin
      @(negedge CLK);
      n++;
    end
    chk("accept_ready", {31'd0, req_ready}, 32'd1);
    @(posedge CLK);
    #1 req_valid = 1'b0;
  endtask

  task automatic handshake(input string tag);
    @(negedge CLK);
    rsp_ready = 1'b1;
    @(posedge CLK);
    #1 rsp_ready = 1'b0;
    chk({tag, "_rspv_clr"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_rdy_back"}, {31'd0, req_ready}, 32'd1);
  endtask

  task automatic access(input string tag, input logic we,
                        input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic exp_err,
                        input logic [3:0] exp_wme,
                        input logic [31:0] exp_rd);
    int c0;
    c0 = wme_cnt;
    send_req(we, f3, a, wd);
    if (!exp_err) begin
      chk({tag, "_wme"}, {28'd0, wme}, {28'd0, exp_wme});
      chk({tag, "_addr"}, address, a);
      chk({tag, "_rspv_early"}, {31'd0, rsp_valid}, 32'd0);
      if (we) chk({tag, "_datain"}, datain, wd);
      @(posedge CLK);
      #1;
    end
    chk({tag, "_rspv"}, {31'd0, rsp_valid}, 32'd1);
    chk({tag, "_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
    chk({tag, "_rdata"}, rsp_rdata, exp_rd);
    chk({tag, "_rdy_busy"}, {31'd0, req_ready}, 32'd0);
    handshake(tag);
    chk({tag, "_wme_cycles"}, 32'(wme_cnt - c0),
        (exp_wme != 4'd0) ? 32'd1 : 32'd0);
  endtask

  initial begin
    int c0;
    for (int i = 0; i < MB; i++) mem[i] = 8'h00;
    Reset      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = '0;
    req_wdata  = '0;
    rsp_ready  = 1'b0;

    #2;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_address", address, 32'd0);
    chk("rst_datain", datain, 32'd0);
    chk("rst_wme", {28'd0, wme}, 32'd0);
    @(negedge CLK);
    Reset = 1'b1;
    #1 chk("rel_ready_low", {31'd0, req_ready}, 32'd0);
    @(posedge CLK);
    #1 chk("rel_ready_high", {31'd0, req_ready}, 32'd1);

    access("sw4", 1, 3'b010, 32'd4, 32'hABCDEF24, 0, 4'b1111, 32'd0);
    access("lw4", 0, 3'b010, 32'd4, 32'd0, 0, 4'b0000, 32'hABCDEF24);
    access("sb17", 1, 3'b000, 32'd17, 32'hABCDEF24, 0, 4'b0001, 32'd0);
    access("lb17", 0, 3'b000, 32'd17, 32'd0, 0, 4'b0000, 32'h00000024);
    access("lb6", 0, 3'b000, 32'd6, 32'd0, 0, 4'b0000, 32'hFFFFFFCD);
    access("lbu6", 0, 3'b100, 32'd6, 32'd0, 0, 4'b0000, 32'h000000CD);
    access("lh6", 0, 3'b001, 32'd6, 32'd0, 0, 4'b0000, 32'hFFFFABCD);
    access("lhu6", 0, 3'b101, 32'd6, 32'd0, 0, 4'b0000, 32'h0000ABCD);
    access("lw1020", 0, 3'b010, 32'd1020, 32'd0, 0, 4'b0000, 32'd0);
    access("lw_top", 0, 3'b010, 32'd1022, 32'd0, 1, 4'b0000, 32'd0);
    access("sbu", 1, 3'b100, 32'd8, 32'h11, 1, 4'b0000, 32'd0);
    access("lw_wrap", 0, 3'b010, 32'hFFFFFFFE, 32'd0, 1, 4'b0000, 32'd0);
    access("f3_bad", 0, 3'b011, 32'd0, 32'd0, 1, 4'b0000, 32'd0);
    access("lw_ok", 0, 3'b010, 32'd4, 32'd0, 0, 4'b0000, 32'hABCDEF24);

    // Response held while the consumer stalls; new requests ignored.
    c0 = wme_cnt;
    send_req(0, 3'b010, 32'd4, 32'd0);
    @(posedge CLK);
    #1;
    chk("hold_rspv0", {31'd0, rsp_valid}, 32'd1);
    chk("hold_rd0", rsp_rdata, 32'hABCDEF24);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'd8;
    req_wdata  = 32'h55667788;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK);
      #1;
      chk("hold_rspv", {31'd0, rsp_valid}, 32'd1);
      chk("hold_rd", rsp_rdata, 32'hABCDEF24);
      chk("hold_rdy", {31'd0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    handshake("hold");
    chk("hold_no_wr", 32'(wme_cnt - c0), 32'd0);
    access("lw8", 0, 3'b010, 32'd8, 32'd0, 0, 4'b0000, 32'd0);

    // Reset during a store's ACCESS cycle.
    c0 = wme_cnt;
    send_req(1, 3'b010, 32'd4, 32'hBBBBBBBB);
    chk("rst_acc_wme_on", {28'd0, wme}, 32'hF);
    #1 Reset = 1'b0;
    #1;
    chk("rst_acc_wme", {28'd0, wme}, 32'd0);
    chk("rst_acc_rspv", {31'd0, rsp_valid}, 32'd0);
    chk("rst_acc_rdy", {31'd0, req_ready}, 32'd0);
    @(negedge CLK);
    Reset = 1'b1;
    @(posedge CLK);
    #1;
    chk("rst_acc_rdy2", {31'd0, req_ready}, 32'd1);
    chk("rst_acc_rspv2", {31'd0, rsp_valid}, 32'd0);
    chk("rst_acc_no_wr", 32'(wme_cnt - c0), 32'd0);
    access("lw4_after", 0, 3'b010, 32'd4, 32'd0, 0, 4'b0000,
           32'hABCDEF24);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
